// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses the UART byte stream into framed commands for the FIR.
//   Frame: SYNC, CMD, LEN, LEN x {lo, hi} words, CHK (XOR of CMD, LEN and payload).
//   CMD 01 writes coefficients and commits on a good checksum; CMD 02 streams samples.
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_rxdatval, i_rxbyte     received byte strobe and data
//   o_coef_we/addr/data      coefficient shadow-bank write
//   o_coef_commit            bank swap pulse after a clean coefficient frame
//   o_smp_valid/data, i_smp_ready  sample handshake (one-entry holding register)
//   o_busy                   frame in progress
//   o_err, o_err_code        error pulse; code 0 timeout, 1 CMD, 2 LEN, 3 checksum
//   o_overflow, i_clr_ovf    sticky dropped-sample flag and its clear
module uart_frame_ctrl #(
    parameter int unsigned NUM_TAPS     = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 25000
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_rxdatval,
    input  logic [7:0]        i_rxbyte,
    output logic              o_coef_we,
    output logic [ADDR_W-1:0] o_coef_addr,
    output logic [DATA_W-1:0] o_coef_data,
    output logic              o_coef_commit,
    output logic              o_smp_valid,
    output logic [DATA_W-1:0] o_smp_data,
    input  logic              i_smp_ready,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic              o_overflow,
    input  logic              i_clr_ovf
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_LO,
        S_HI,
        S_CHK
    } state_t;

    state_t          state;
    logic            cmd_coef;
    logic [7:0]      len_q;
    logic [7:0]      wcnt;
    logic [7:0]      lo_q;
    logic [7:0]      chk_q;
    logic [TO_W-1:0] tcnt;

    logic              push_c;
    logic              xfer_c;
    logic [7:0]        wcnt_inc_c;
    logic [DATA_W-1:0] word_c;

    assign wcnt_inc_c = wcnt + 8'd1;
    assign word_c     = DATA_W'({i_rxbyte, lo_q});
    assign push_c     = i_rxdatval && (state == S_HI) && !cmd_coef;
    assign xfer_c     = o_smp_valid && i_smp_ready;

    // Frame parser, timeout watchdog and registered coefficient/error outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= S_HUNT;
            cmd_coef      <= 1'b0;
            len_q         <= 8'd0;
            wcnt          <= 8'd0;
            lo_q          <= 8'd0;
            chk_q         <= 8'd0;
            tcnt          <= '0;
            o_coef_we     <= 1'b0;
            o_coef_addr   <= '0;
            o_coef_data   <= '0;
            o_coef_commit <= 1'b0;
            o_busy        <= 1'b0;
            o_err         <= 1'b0;
            o_err_code    <= 2'd0;
        end else begin
            o_coef_we     <= 1'b0;
            o_coef_commit <= 1'b0;
            o_err         <= 1'b0;
            if (i_rxdatval) begin
                // A byte always beats a coincident timeout.
                tcnt <= '0;
                case (state)
                    S_HUNT: begin
                        if (i_rxbyte == SYNC_BYTE) begin
                            state  <= S_CMD;
                            o_busy <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (i_rxbyte == 8'h01 || i_rxbyte == 8'h02) begin
                            cmd_coef <= (i_rxbyte == 8'h01);
                            chk_q    <= i_rxbyte;
                            state    <= S_LEN;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= 2'd1;
                            state      <= S_HUNT;
                            o_busy     <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        if (i_rxbyte == 8'd0 || (cmd_coef && i_rxbyte > 8'(NUM_TAPS))) begin
                            o_err      <= 1'b1;
                            o_err_code <= 2'd2;
                            state      <= S_HUNT;
                            o_busy     <= 1'b0;
                        end else begin
                            len_q <= i_rxbyte;
                            wcnt  <= 8'd0;
                            chk_q <= chk_q ^ i_rxbyte;
                            state <= S_LO;
                        end
                    end
                    S_LO: begin
                        lo_q  <= i_rxbyte;
                        chk_q <= chk_q ^ i_rxbyte;
                        state <= S_HI;
                    end
                    S_HI: begin
                        chk_q <= chk_q ^ i_rxbyte;
                        if (cmd_coef) begin
                            o_coef_we   <= 1'b1;
                            o_coef_addr <= ADDR_W'(wcnt);
                            o_coef_data <= word_c;
                        end
                        wcnt  <= wcnt_inc_c;
                        state <= (wcnt_inc_c == len_q) ? S_CHK : S_LO;
                    end
                    S_CHK: begin
                        if (i_rxbyte == chk_q) begin
                            o_coef_commit <= cmd_coef;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= 2'd3;
                        end
                        state  <= S_HUNT;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= S_HUNT;
                        o_busy <= 1'b0;
                    end
                endcase
            end else if (state != S_HUNT) begin
                if (tcnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                    o_err      <= 1'b1;
                    o_err_code <= 2'd0;
                    state      <= S_HUNT;
                    o_busy     <= 1'b0;
                    tcnt       <= '0;
                end else begin
                    tcnt <= tcnt + TO_W'(1);
                end
            end
        end
    end

    // One-entry sample holding register; a word arriving while full and stalled is dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_smp_valid <= 1'b0;
            o_smp_data  <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (push_c) begin
                if (!o_smp_valid || xfer_c) begin
                    o_smp_valid <= 1'b1;
                    o_smp_data  <= word_c;
                end
            end else if (xfer_c) begin
                o_smp_valid <= 1'b0;
            end
            if (push_c && o_smp_valid && !xfer_c) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
